// File: rtl/bomb_pkg.sv
// Shared types, default constants and helpers for the bomb master controller.
package bomb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_DEFUSED  = 2'd2,
    ST_EXPLODED = 2'd3
  } state_t;

  localparam int          CLK_HZ_DEFAULT        = 65000000;
  localparam int          START_SECONDS_DEFAULT = 300;
  localparam int          MAX_STRIKES_DEFAULT   = 3;
  localparam logic [15:0] LFSR_SEED_DEFAULT     = 16'hACE1;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] n;
    n = 6'd0;
    for (int i = 0; i < 32; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ({1'b0, s[15:1]} ^ LFSR_TAPS) : {1'b0, s[15:1]};
  endfunction

endpackage

// File: rtl/bomb_controller_one_hz_gen.sv
// Free-running period counter producing a one-cycle tick every CLK_HZ cycles;
// also used by the display blink logic.
module one_hz_gen #(
  parameter int CLK_HZ = 65000000
) (
  input  logic clock_65mhz,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nx_s;
  logic          tick_r;

  // Next count: clear restarts the period, otherwise wrap after LAST.
  always_comb begin
    count_nx_s = count_r;
    if (clear) begin
      count_nx_s = {CW{1'b0}};
    end else if (count_r == LAST) begin
      count_nx_s = {CW{1'b0}};
    end else begin
      count_nx_s = count_r + CW'(1'b1);
    end
  end

  // Counter register; tick is registered so it is high exactly while count == LAST.
  always_ff @(posedge clock_65mhz or posedge reset) begin
    if (reset) begin
      count_r <= {CW{1'b0}};
      tick_r  <= 1'b0;
    end else begin
      count_r <= count_nx_s;
      tick_r  <= (count_nx_s == LAST);
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/bomb_controller.sv
// Bomb master controller: arms the puzzle modules, runs the countdown, counts
// strikes, decides DEFUSED/EXPLODED and owns the shared LFSR.
module bomb_controller
  import bomb_pkg::*;
#(
  parameter int          NUM_MODULES   = 4,
  parameter int          CLK_HZ        = CLK_HZ_DEFAULT,
  parameter int          START_SECONDS = START_SECONDS_DEFAULT,
  parameter int          MAX_STRIKES   = MAX_STRIKES_DEFAULT,
  parameter logic [15:0] LFSR_SEED     = LFSR_SEED_DEFAULT
) (
  input  logic                   clock_65mhz,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NUM_MODULES-1:0] strike_in,
  input  logic [NUM_MODULES-1:0] defused_in,
  input  logic [NUM_MODULES-1:0] rng_enable,
  output logic [NUM_MODULES-1:0] module_enable,
  output logic                   one_hz_enable,
  output logic [3:0]             rng_output,
  output logic [9:0]             seconds_left,
  output logic [1:0]             strike_count,
  output logic                   armed,
  output logic                   defused,
  output logic                   exploded
);

  localparam int PW = $clog2(NUM_MODULES + 1);
  // sum width leaves headroom above both the 2-bit count and the popcount
  localparam int SW = ((PW > 2) ? PW : 2) + 1;
  localparam logic [9:0]             START_VAL = 10'(START_SECONDS);
  localparam logic [SW-1:0]          MAX_VAL   = SW'(MAX_STRIKES);
  localparam logic [NUM_MODULES-1:0] ALL_ONES  = {NUM_MODULES{1'b1}};
  localparam logic [NUM_MODULES-1:0] ALL_ZERO  = {NUM_MODULES{1'b0}};

  state_t                   state_r, state_nx_s;
  logic                     start_prev_r;
  logic [NUM_MODULES-1:0]   strike_prev_r;
  logic                     start_edge_s;
  logic [NUM_MODULES-1:0]   strike_edge_s;
  logic [PW-1:0]            pop_s;
  logic [SW-1:0]            strike_sum_s;
  logic [9:0]               seconds_r, seconds_nx_s;
  logic [1:0]               strikes_r, strikes_nx_s;
  logic                     timeout_s, max_hit_s;
  logic                     tick_s, clear_s;
  logic [NUM_MODULES-1:0]   enable_r;
  logic                     armed_r, defused_r, exploded_r;
  logic [15:0]              lfsr_r;

  assign start_edge_s  = start & ~start_prev_r;
  assign strike_edge_s = strike_in & ~strike_prev_r;
  assign pop_s         = PW'(popcount(32'(strike_edge_s)));
  assign strike_sum_s  = SW'(strikes_r) + SW'(pop_s);
  assign clear_s       = (state_r == ST_IDLE) && start_edge_s;

  one_hz_gen #(.CLK_HZ(CLK_HZ)) u_one_hz (
    .clock_65mhz (clock_65mhz),
    .reset       (reset),
    .clear       (clear_s),
    .tick        (tick_s)
  );

  // Next state, countdown and strike bookkeeping; explosion outranks defuse.
  always_comb begin
    state_nx_s   = state_r;
    seconds_nx_s = seconds_r;
    strikes_nx_s = strikes_r;
    timeout_s    = 1'b0;
    max_hit_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_edge_s) begin
          state_nx_s   = ST_ARMED;
          seconds_nx_s = START_VAL;
          strikes_nx_s = 2'd0;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (tick_s && (seconds_r != 10'd0)) begin
          seconds_nx_s = seconds_r - 10'd1;
          timeout_s    = (seconds_r == 10'd1);
        end else begin
          seconds_nx_s = seconds_r;
        end
        if (strike_sum_s >= MAX_VAL) begin
          strikes_nx_s = MAX_VAL[1:0];
          max_hit_s    = 1'b1;
        end else begin
          strikes_nx_s = strike_sum_s[1:0];
        end
        if (timeout_s || max_hit_s) begin
          state_nx_s = ST_EXPLODED;
        end else if (defused_in == ALL_ONES) begin
          state_nx_s = ST_DEFUSED;
        end else begin
          state_nx_s = ST_ARMED;
        end
      end
      ST_DEFUSED, ST_EXPLODED: begin
        state_nx_s = state_r;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State, game counters, registered flags/enables and input edge history.
  always_ff @(posedge clock_65mhz or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      seconds_r     <= START_VAL;
      strikes_r     <= 2'd0;
      enable_r      <= ALL_ZERO;
      armed_r       <= 1'b0;
      defused_r     <= 1'b0;
      exploded_r    <= 1'b0;
      start_prev_r  <= 1'b0;
      strike_prev_r <= ALL_ZERO;
    end else begin
      state_r       <= state_nx_s;
      seconds_r     <= seconds_nx_s;
      strikes_r     <= strikes_nx_s;
      enable_r      <= (state_nx_s == ST_ARMED) ? ALL_ONES : ALL_ZERO;
      armed_r       <= (state_nx_s == ST_ARMED);
      defused_r     <= (state_nx_s == ST_DEFUSED);
      exploded_r    <= (state_nx_s == ST_EXPLODED);
      start_prev_r  <= start;
      strike_prev_r <= strike_in;
    end
  end

  // Shared LFSR advances once per cycle while any module requests it.
  always_ff @(posedge clock_65mhz or posedge reset) begin
    if (reset) begin
      lfsr_r <= LFSR_SEED;
    end else if (|rng_enable) begin
      lfsr_r <= lfsr_step(lfsr_r);
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  assign module_enable = enable_r;
  assign one_hz_enable = tick_s;
  assign rng_output    = lfsr_r[3:0];
  assign seconds_left  = seconds_r;
  assign strike_count  = strikes_r;
  assign armed         = armed_r;
  assign defused       = defused_r;
  assign exploded      = exploded_r;

endmodule
